// File: rtl/eth_tx_framer.sv
// eth_tx_framer: MII-nibble Ethernet TX framer adding preamble/SFD, zero pad, CRC-32 FCS and inter-frame gap.
// Outputs are registered alongside the state, so they always show the current state's nibble.
module eth_tx_framer #(
    parameter int IFG_NIBBLES = 24,
    parameter int MIN_PAYLOAD = 60,
    parameter bit PAD_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       mac_txen,
    output logic [3:0] mac_txd,
    output logic       mac_txer,
    output logic       busy
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRE   = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAD   = 3'd3;
    localparam logic [2:0] FCS   = 3'd4;
    localparam logic [2:0] IFG   = 3'd5;
    localparam logic [2:0] UNDR  = 3'd6;
    localparam logic [2:0] DRAIN = 3'd7;
    localparam logic [15:0] MIN_B = 16'(MIN_PAYLOAD);
    // The IDLE cycle is the final gap nibble, so IFG itself lasts one cycle less.
    localparam logic [7:0] IFG_END = 8'(IFG_NIBBLES - 2);

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [3:0]  hi;
    logic [15:0] bcnt;
    logic [15:0] bcnt_inc;
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [2:0]  fi;
    logic        last_f;
    logic        acc;
    logic        pad_more;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign in_ready = (state == PRE && cnt == 8'd15) || (state == DATA && cnt[0] && !last_f) || state == DRAIN;
    assign acc      = in_valid && in_ready;
    assign busy     = state != IDLE;
    assign bcnt_inc = bcnt + {15'd0, bcnt != 16'hFFFF};
    assign pad_more = PAD_EN && bcnt < MIN_B;
    assign fcs      = ~crc;
    assign fi       = cnt[2:0] + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            hi       <= 4'd0;
            bcnt     <= 16'd0;
            crc      <= 32'hFFFFFFFF;
            last_f   <= 1'b0;
            mac_txen <= 1'b0;
            mac_txd  <= 4'd0;
            mac_txer <= 1'b0;
        end else begin
            mac_txer <= 1'b0;
            if (acc) begin
                hi     <= in_data[7:4];
                crc    <= crc_upd(crc, in_data);
                bcnt   <= bcnt_inc;
                last_f <= in_last;
            end
            case (state)
                IDLE: if (in_valid) begin
                    state    <= PRE;
                    cnt      <= 8'd0;
                    mac_txen <= 1'b1;
                    mac_txd  <= 4'h5;
                    crc      <= 32'hFFFFFFFF;
                    bcnt     <= 16'd0;
                    last_f   <= 1'b0;
                end
                PRE: if (cnt != 8'd15) begin
                    cnt     <= cnt + 8'd1;
                    mac_txd <= cnt == 8'd14 ? 4'hD : 4'h5;
                end else if (in_valid) begin
                    state   <= DATA;
                    cnt     <= 8'd0;
                    mac_txd <= in_data[3:0];
                end else begin
                    state    <= UNDR;
                    mac_txd  <= 4'd0;
                    mac_txer <= 1'b1;
                end
                DATA: if (!cnt[0]) begin
                    cnt     <= 8'd1;
                    mac_txd <= hi;
                end else if (last_f && pad_more) begin
                    state   <= PAD;
                    cnt     <= 8'd0;
                    mac_txd <= 4'd0;
                    crc     <= crc_upd(crc, 8'h00);
                    bcnt    <= bcnt_inc;
                end else if (last_f) begin
                    state   <= FCS;
                    cnt     <= 8'd0;
                    mac_txd <= fcs[3:0];
                end else if (in_valid) begin
                    cnt     <= 8'd0;
                    mac_txd <= in_data[3:0];
                end else begin
                    state    <= UNDR;
                    mac_txd  <= 4'd0;
                    mac_txer <= 1'b1;
                end
                PAD: if (!cnt[0]) begin
                    cnt <= 8'd1;
                end else if (pad_more) begin
                    cnt  <= 8'd0;
                    crc  <= crc_upd(crc, 8'h00);
                    bcnt <= bcnt_inc;
                end else begin
                    state   <= FCS;
                    cnt     <= 8'd0;
                    mac_txd <= fcs[3:0];
                end
                FCS: if (cnt != 8'd7) begin
                    cnt     <= cnt + 8'd1;
                    mac_txd <= fcs[{fi, 2'b00} +: 4];
                end else begin
                    state    <= IFG;
                    cnt      <= 8'd0;
                    mac_txen <= 1'b0;
                    mac_txd  <= 4'd0;
                end
                IFG: if (cnt == IFG_END) state <= IDLE;
                     else cnt <= cnt + 8'd1;
                UNDR: begin
                    state    <= DRAIN;
                    mac_txen <= 1'b0;
                    mac_txd  <= 4'd0;
                end
                DRAIN: if (in_valid && in_last) begin
                    state <= IFG;
                    cnt   <= 8'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: random and directed frames on a no-pad and a padding framer, compared per nibble
// against expected frames built from byte lists with an independent bit-serial CRC-32.
module tb_eth_tx_framer;
    typedef logic [7:0] bq_t[$];
    localparam int IFG = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    int sel = 0;
    logic rdy0, rdy1, en0, en1, er0, er1, busy0, busy1;
    logic [3:0] txd0, txd1;
    logic rdy_m, en_m, er_m, busy_m;
    logic [3:0] txd_m;

    int checks = 0;
    int failures = 0;
    logic [4:0] exp_q[$];
    int flen_q[$];
    logic [3:0] cap[$];
    logic [3:0] lit[$];
    logic [3:0] fcs_lit[8];
    int gap = 0, last_gap = 0, hi_len = 0, last_len = 0, want_len = 0;
    logic prev_en = 1'b0, prev_rdy = 1'b0, mute = 1'b0;

    always #5 clk = ~clk;

    eth_tx_framer #(.PAD_EN(1'b0)) u_nopad (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid && sel == 0), .in_last(in_last),
        .in_ready(rdy0), .mac_txen(en0), .mac_txd(txd0), .mac_txer(er0), .busy(busy0)
    );
    eth_tx_framer #(.PAD_EN(1'b1)) u_pad (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid && sel == 1), .in_last(in_last),
        .in_ready(rdy1), .mac_txen(en1), .mac_txd(txd1), .mac_txer(er1), .busy(busy1)
    );

    assign rdy_m  = sel == 1 ? rdy1 : rdy0;
    assign en_m   = sel == 1 ? en1 : en0;
    assign er_m   = sel == 1 ? er1 : er0;
    assign txd_m  = sel == 1 ? txd1 : txd0;
    assign busy_m = sel == 1 ? busy1 : busy0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Non-reflected shift register fed LSB-first, result bit-reversed and inverted.
    function automatic logic [31:0] crc_model(input bq_t b);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [31:0] r;
        foreach (b[i])
            for (int j = 0; j < 8; j++)
                c = {c[30:0], 1'b0} ^ ((c[31] ^ b[i][j]) ? 32'h04C11DB7 : 32'h0);
        for (int j = 0; j < 32; j++) r[j] = ~c[31 - j];
        return r;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic void expect_frame(input bq_t b, input bit pad, input int undr);
        bq_t p = b;
        logic [31:0] f;
        int n0 = exp_q.size();
        for (int i = 0; i < 15; i++) exp_q.push_back(5'h05);
        exp_q.push_back(5'h0D);
        if (undr >= 0) begin
            for (int i = 0; i < undr; i++) begin
                exp_q.push_back({1'b0, b[i][3:0]});
                exp_q.push_back({1'b0, b[i][7:4]});
            end
            exp_q.push_back(5'h10);
        end else begin
            while (pad && p.size() < 60) p.push_back(8'h00);
            foreach (p[i]) begin
                exp_q.push_back({1'b0, p[i][3:0]});
                exp_q.push_back({1'b0, p[i][7:4]});
            end
            f = crc_model(p);
            for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, f[4 * i +: 4]});
        end
        flen_q.push_back(exp_q.size() - n0);
    endfunction

    task automatic put_byte(input logic [7:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin @(negedge clk); t++; end while (!rdy_m && t < 300);
        chk("in_ready_timeout", int'(rdy_m), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bq_t b, input int undr, input bit hold);
        if (!mute) expect_frame(b, sel == 1, undr);
        foreach (b[i]) begin
            if (i == undr) begin
                int t = 0;
                in_valid = 1'b0;
                do begin @(negedge clk); t++; end while (!rdy_m && t < 300);
                chk("underrun_slot", int'(rdy_m), 1);
                @(posedge clk);
                #1;
            end
            put_byte(b[i], i == b.size() - 1);
        end
        if (!hold) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge clk); t++; end while ((busy_m || en_m) && t < 3000);
        chk("idle_timeout", int'(busy_m), 0);
    endtask

    always @(negedge clk) begin
        if (!mute) begin
            if (en_m) begin
                if (!prev_en) begin
                    chk("ifg_min", int'(gap >= IFG), 1);
                    last_gap = gap;
                    hi_len = 0;
                    cap.delete();
                    want_len = flen_q.size() > 0 ? flen_q.pop_front() : -1;
                end
                hi_len++;
                cap.push_back(txd_m);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_nibble got=%0h want=none at %0t", {er_m, txd_m}, $time);
                end else chk("nibble", int'({er_m, txd_m}), int'(exp_q.pop_front()));
                if (rdy_m) chk("in_ready_alternate", int'(prev_rdy), 0);
            end else begin
                chk("idle_lines", int'({er_m, txd_m}), 0);
                if (prev_en) begin
                    last_len = hi_len;
                    chk("frame_len", hi_len, want_len);
                    gap = 0;
                end
                gap++;
            end
        end
        prev_en  = en_m;
        prev_rdy = rdy_m;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bq_t s;
        bit h;
        fcs_lit = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        repeat (3) @(negedge clk);
        chk("rst_outputs", int'({en0, en1, txd0, txd1, er0, er1, busy0, busy1, rdy0, rdy1}), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_after_reset", int'({en0, en1, txd0, txd1, busy0, busy1, rdy0, rdy1}), 0);
        end

        for (int d = 1; d <= 9; d++) s.push_back(8'(8'h30 + d));
        chk("crc_model_pin", int'(crc_model(s)), int'(32'hCBF43926));
        sel = 0;
        send(s, -1, 1'b0);
        wait_idle();
        for (int i = 0; i < 15; i++) lit.push_back(4'h5);
        lit.push_back(4'hD);
        for (int d = 1; d <= 9; d++) begin lit.push_back(4'(d)); lit.push_back(4'h3); end
        for (int i = 0; i < 8; i++) lit.push_back(fcs_lit[i]);
        chk("ascii_len", cap.size(), 42);
        for (int i = 0; i < lit.size() && i < cap.size(); i++) chk("ascii_nibble", int'(cap[i]), int'(lit[i]));

        for (int k = 0; k < 4; k++) begin
            h = k < 3 && $urandom_range(0, 1) == 1;
            send(rand_bytes($urandom_range(1, 100)), -1, h);
            if (!h) repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        wait_idle();

        sel = 1;
        s = {8'hAB};
        send(s, -1, 1'b0);
        wait_idle();
        chk("pad_frame_len", last_len, 144);

        send(rand_bytes(64), -1, 1'b1);
        send(rand_bytes(64), -1, 1'b0);
        wait_idle();
        chk("b2b_gap", last_gap, 24);
        chk("b2b_len", last_len, 152);

        send(rand_bytes(40), 10, 1'b0);
        wait_idle();
        chk("underrun_len", last_len, 37);
        send(rand_bytes(40), -1, 1'b0);
        wait_idle();

        for (int k = 0; k < 5; k++) begin
            h = k < 4 && $urandom_range(0, 1) == 1;
            send(rand_bytes($urandom_range(1, 90)), -1, h);
            if (!h) repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        wait_idle();

        mute = 1'b1;
        s = rand_bytes(5);
        foreach (s[i]) put_byte(s[i], 1'b0);
        #2;
        chk("busy_mid_frame", int'(busy_m), 1);
        rst_n = 1'b0;
        #1;
        chk("async_abort", int'({en_m, txd_m, er_m, busy_m, rdy_m}), 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mute = 1'b0;
        repeat (30) @(negedge clk);
        send(rand_bytes(20), -1, 1'b0);
        wait_idle();
        chk("post_reset_len", last_len, 144);

        chk("exp_drained", exp_q.size(), 0);
        chk("flen_drained", flen_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
